div_sequencer: RTL and testbench
================================

# div_sequencer

Execute-stage controller for the iterative divider and owner of the shared 34-bit ALU adder. It accepts DIV/DIVU/REM/REMU requests from issue and drives the divider's enable, funct3 and operands. While a division runs, it steers the divider's adder operands into the shared adder and returns the adder result. It captures the final result and presents it on a valid/ready response port.

## Interface
Parameters:
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush; aborts the in-flight operation.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_funct3_i  in  3  DIV/DIVU/REM/REMU encoding.
- req_a_i, req_b_i  in  32  dividend, divisor.
- req_rd_i  in  5  destination register tag.
- resp_valid_o / resp_ready_i  out/in  1  response handshake.
- resp_data_o  out  32  result.
- resp_rd_o  out  5  tag of the response.
- div_en_o  out  1  divider enable.
- div_funct3_o  out  3  latched funct3 to the divider.
- div_a_o, div_b_o  out  32  latched operands to the divider.
- div_finish_i  in  1  divider done; combinational within a cycle.
- div_sub_i  in  1  divider adder subtract request.
- div_operand_a_i, div_operand_b_i  in  32  divider adder operands.
- div_result_i  in  32  divider result; valid when div_finish_i=1.
- alu_a_i, alu_b_i  in  32  ALU adder operands.
- alu_sub_i  in  1  ALU subtract request.
- adder_result_ext_o  out  34  shared adder result.
- busy_o  out  1  high in RUN or DONE.

## Operation
- Shared adder: A={1'b0,a,1'b1}, B={1'b0,b^{32{sub}},sub}, adder_result_ext_o=A+B mod 2^34.
  - Bits [32:1] are a±b; bit 32 is the sum MSB; bit 33 is carry-out; bit 0 is don't-care.
- Operand mux: in RUN, a/b/sub come from the div_* inputs. In all other states they come from alu_*.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch funct3/a/b/rd and go to RUN.
- RUN:
  - div_en_o=1.
  - On div_finish_i, register div_result_i into resp_data_o and go to DONE.
- DONE:
  - resp_valid_o=1 and div_en_o=0.
  - On resp_ready_i, go to IDLE.
  - DONE guarantees at least one cycle with div_en_o low between operations, which the divider needs to clear its round counter.
- flush_i:
  - Any state goes to IDLE next cycle and div_en_o drops.
  - A pending response is discarded.
  - flush_i and req_valid_i in the same IDLE cycle: the request is not accepted.
- rst: same as flush_i, and also clears the cache.
- Reset values: req_ready_o=1; resp_valid_o=0; resp_data_o=0; resp_rd_o=0; div_en_o=0; div_funct3_o=0; div_a_o=0; div_b_o=0; busy_o=0.
- Latched operands are stable for the whole of RUN; req_* changes are ignored outside IDLE.

## Timing
- Acceptance cycle = cycle 0. RUN starts at cycle 1.
- Normal division: 34 RUN cycles; resp_valid_o rises in cycle 35.
- Special cases (zero operand, DIVU with divisor ≥ 2^31): finish in the first RUN cycle; resp_valid_o rises in cycle 2.
- Response stalls indefinitely under backpressure; resp_data_o and resp_rd_o are held stable.
- Throughput: one operation per (latency + 1) cycles at best; there is no overlap.
- adder_result_ext_o is purely combinational from the mux output, with no register.

## Configuration
- DIV_RESULT_CACHE_EN defined:
  - A one-entry cache holds {funct3, a, b, result}, updated on every completed (non-flushed) operation.
  - An accepted request matching all three fields goes IDLE→DONE with the cached result. resp_valid_o rises in cycle 1 and div_en_o stays low.
  - Cleared by rst only.
- Undefined: no cache; every request runs the divider.

## Structure
- In package libalu:
  - funct3 constants DIV/DIVU/REM/REMU.
  - enum typedef div_seq_state_e {IDLE, RUN, DONE}.
- Sub-module shared_adder34: the mux-free 34-bit add/sub. It is reused by the ALU when the sequencer is absent.

## Test plan
- DIVU 100/7, resp_ready_i=1: resp_data_o=14 in cycle 35; div_en_o high for cycles 1–34.
- REM -7/2 (0xFFFFFFF9, 2): resp_data_o=0xFFFFFFFF. DIV -7/2: 0xFFFFFFFD.
- DIV 7/0: resp_data_o=0xFFFFFFFF in cycle 2. REMU 7/0: 7 in cycle 2.
- resp_ready_i low for 10 cycles after DONE: resp_valid_o and resp_data_o held; req_ready_o=0; next request accepted the cycle after ready.
- flush_i asserted in RUN cycle 10: IDLE next cycle, div_en_o=0, no response. A following DIV 20/3 returns 6 with full latency.
- With DIV_RESULT_CACHE_EN: DIVU 100/7 issued twice. The second returns 14 in cycle 1 and div_en_o never rises. DIVU 100/8 misses the cache.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider sequencer.
//   - RV32M funct3 encodings of the four division operations.
//   - div_seq_state_e: sequencer FSM states (IDLE, RUN, DONE).
package libalu;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_seq_state_e;

endpackage

// File: rtl/shared_adder34.sv
// 34-bit add/subtract core shared by the ALU and the iterative divider.
//   a, b   : 32-bit operands
//   sub    : 1 selects a - b, 0 selects a + b
//   result : {carry, a+-b, don't-care}; bits [32:1] hold a+-b, bit 33 is the
//            carry-out.
// The low guard bits ({a,1} + {~b,1}) inject the +1 of the two's-complement
// subtraction without a separate carry-in, so the whole thing is one adder.
module shared_adder34 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [33:0] result
);

  logic [33:0] op_a;
  logic [33:0] op_b;

  assign op_a   = {1'b0, a, 1'b1};
  assign op_b   = {1'b0, b ^ {32{sub}}, sub};
  assign result = op_a + op_b;

endmodule

// File: rtl/div_sequencer.sv
// Execute-stage controller for the iterative divider; also owns the shared
// 34-bit adder.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   flush_i               : aborts whatever is in flight, back to IDLE
//   req_*                 : request from issue (funct3, dividend, divisor, rd)
//   resp_*                : result and rd tag back to writeback
//   div_en_o/funct3/a/b   : control and latched operands to the divider
//   div_finish_i/result_i : divider completion and result (same cycle)
//   div_sub_i/operand_*   : divider's adder request, routed while in RUN
//   alu_*                 : ALU adder request, routed in every other state
//   adder_result_ext_o    : combinational shared adder output
//   busy_o                : high in RUN or DONE
//   state_dbg             : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid never depends on ready. A request is additionally
// refused in a cycle where flush_i is high.
//
// Optional feature: define DIV_RESULT_CACHE_EN to add a one-entry result
// cache; a matching request skips the divider and goes straight to DONE.
module div_sequencer
  import libalu::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic [4:0]      req_rd_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  output logic [4:0]      resp_rd_o,
  output logic            div_en_o,
  output logic [2:0]      div_funct3_o,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  input  logic            div_finish_i,
  input  logic            div_sub_i,
  input  logic [XLEN-1:0] div_operand_a_i,
  input  logic [XLEN-1:0] div_operand_b_i,
  input  logic [XLEN-1:0] div_result_i,
  input  logic [XLEN-1:0] alu_a_i,
  input  logic [XLEN-1:0] alu_b_i,
  input  logic            alu_sub_i,
  output logic [XLEN+1:0] adder_result_ext_o,
  output logic            busy_o,
  output div_seq_state_e  state_dbg
);

  div_seq_state_e state;
  div_seq_state_e next_state;

  logic            accept;       // request handshake completes this cycle
  logic            capture_div;  // divider result is taken this cycle
  logic            hit;          // accepted request can be served from cache
  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic            add_sub;

  assign accept      = (state == IDLE) && req_valid_i && !flush_i;
  assign capture_div = (state == RUN) && div_finish_i && !flush_i;
  assign state_dbg   = state;

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_valid;
  logic [2:0]      cache_funct3;
  logic [XLEN-1:0] cache_a;
  logic [XLEN-1:0] cache_b;
  logic [XLEN-1:0] cache_result;

  assign hit = cache_valid && (cache_funct3 == req_funct3_i) &&
               (cache_a == req_a_i) && (cache_b == req_b_i);

  // Only rst invalidates the entry; a flush leaves a completed result usable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid  <= 1'b0;
      cache_funct3 <= '0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_result <= '0;
    end else if (capture_div) begin
      cache_valid  <= 1'b1;
      cache_funct3 <= div_funct3_o;
      cache_a      <= div_a_o;
      cache_b      <= div_b_o;
      cache_result <= div_result_i;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Next-state logic. flush_i overrides every transition.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = hit ? DONE : RUN;
      RUN:  if (div_finish_i) next_state = DONE;
      DONE: if (resp_ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush_i) next_state = IDLE;
  end

  // Moore outputs. div_en_o is low in DONE, so the divider always sees at
  // least one idle cycle between operations to clear its round counter.
  always_comb begin
    req_ready_o  = 1'b0;
    div_en_o     = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b0;
    unique case (state)
      IDLE: req_ready_o = 1'b1;
      RUN: begin
        div_en_o = 1'b1;
        busy_o   = 1'b1;
      end
      DONE: begin
        resp_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      default: req_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      resp_data_o  <= '0;
      resp_rd_o    <= '0;
      div_funct3_o <= '0;
      div_a_o      <= '0;
      div_b_o      <= '0;
    end else begin
      state <= next_state;
      // Operands are captured only on acceptance, so they stay stable for
      // the whole of RUN and DONE regardless of what issue drives.
      if (accept) begin
        div_funct3_o <= req_funct3_i;
        div_a_o      <= req_a_i;
        div_b_o      <= req_b_i;
        resp_rd_o    <= req_rd_i;
      end
`ifdef DIV_RESULT_CACHE_EN
      if (accept && hit) resp_data_o <= cache_result;
`endif
      if (capture_div) resp_data_o <= div_result_i;
    end
  end

  // Only the divider's own rounds use the adder in RUN; the ALU has it
  // otherwise.
  always_comb begin
    add_a   = alu_a_i;
    add_b   = alu_b_i;
    add_sub = alu_sub_i;
    if (state == RUN) begin
      add_a   = div_operand_a_i;
      add_b   = div_operand_b_i;
      add_sub = div_sub_i;
    end
  end

  shared_adder34 u_adder (
    .a      (add_a),
    .b      (add_b),
    .sub    (add_sub),
    .result (adder_result_ext_o)
  );

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer. A divider stand-in answers the
// sequencer; a timeline model (when each transaction should be running or
// responding, and with which result) is compared against the DUT every cycle.
module tb_div_sequencer;
  import libalu::*;

  localparam int INF = 32'h3fff_ffff;
`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 0;
`else
  localparam int HIT_LAT = 34;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i = 3'b0;
  logic [31:0] req_a_i = '0;
  logic [31:0] req_b_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        div_en_o;
  logic [2:0]  div_funct3_o;
  logic [31:0] div_a_o;
  logic [31:0] div_b_o;
  logic        div_finish_i;
  logic        div_sub_i;
  logic [31:0] div_operand_a_i;
  logic [31:0] div_operand_b_i;
  logic [31:0] div_result_i;
  logic [31:0] alu_a_i = '0;
  logic [31:0] alu_b_i = '0;
  logic        alu_sub_i = 1'b0;
  logic [33:0] adder_result_ext_o;
  logic        busy_o;
  div_seq_state_e state_dbg;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_rd_i(req_rd_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o),
    .div_en_o(div_en_o), .div_funct3_o(div_funct3_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_finish_i(div_finish_i), .div_sub_i(div_sub_i),
    .div_operand_a_i(div_operand_a_i), .div_operand_b_i(div_operand_b_i),
    .div_result_i(div_result_i),
    .alu_a_i(alu_a_i), .alu_b_i(alu_b_i), .alu_sub_i(alu_sub_i),
    .adder_result_ext_o(adder_result_ext_o), .busy_o(busy_o),
    .state_dbg(state_dbg)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_div(input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f3)
      DIV:  if (b == 0) return 32'hffff_ffff;
            else if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
            else return 32'(sa / sb);
      DIVU: if (b == 0) return 32'hffff_ffff; else return a / b;
      REM:  if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'h0;
            else return 32'(sa % sb);
      REMU: if (b == 0) return a; else return a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Divider cycle count: one round for the early-out cases, 34 otherwise.
  function automatic int div_lat(input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
    if (a == 0 || b == 0 || (f3 == DIVU && b[31])) return 1;
    return 34;
  endfunction

  // a +- b as 33 bits {carry, sum}; equals adder_result_ext_o[33:1].
  function automatic logic [32:0] adder_ref(input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
    logic [63:0] v;
    if (s) v = {32'b0, a} + 64'h1_0000_0000 - {32'b0, b};
    else   v = {32'b0, a} + {32'b0, b};
    return v[32:0];
  endfunction

  // ---------------- divider stand-in ----------------
  int stub_cnt = 0;
  always @(posedge clk) stub_cnt <= div_en_o ? stub_cnt + 1 : 0;

  always_comb begin
    div_finish_i    = div_en_o &&
                      (stub_cnt == div_lat(div_funct3_o, div_a_o, div_b_o) - 1);
    div_result_i    = div_finish_i ? ref_div(div_funct3_o, div_a_o, div_b_o)
                                   : 32'hdead_beef;
    div_operand_a_i = 32'h1357_9bdf ^ (32'(stub_cnt) * 32'h0101_0101);
    div_operand_b_i = div_a_o ^ 32'(stub_cnt);
    div_sub_i       = 1'(stub_cnt & 1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Timeline model of the transaction in flight.
  int          run_lo = INF, run_hi = INF, done_lo = INF, done_hi = INF;
  logic [2:0]  m_f3 = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [4:0]  m_rd = '0;
  logic        mc_valid = 1'b0;
  logic [2:0]  mc_f3 = '0;
  logic [31:0] mc_a = '0, mc_b = '0;
  bit          chk_en = 1'b0;
  bit          alu_rand = 1'b0;

  bit in_run, in_done;
  logic [32:0] exp_add;
  always @(negedge clk) begin
    if (chk_en) begin
      in_run  = (cyc >= run_lo) && (cyc <= run_hi);
      in_done = (cyc >= done_lo) && (cyc <= done_hi);
      check("div_en", 64'(div_en_o), 64'(in_run));
      check("resp_valid", 64'(resp_valid_o), 64'(in_done));
      check("busy", 64'(busy_o), 64'(in_run || in_done));
      check("req_ready", 64'(req_ready_o), 64'(!(in_run || in_done)));
      check("state_dbg", 64'(state_dbg), 64'(in_run ? RUN : in_done ? DONE : IDLE));
      exp_add = in_run ? adder_ref(div_operand_a_i, div_operand_b_i, div_sub_i)
                       : adder_ref(alu_a_i, alu_b_i, alu_sub_i);
      check("adder", 64'(adder_result_ext_o[33:1]), 64'(exp_add));
      if (in_run || in_done) begin
        check("div_funct3", 64'(div_funct3_o), 64'(m_f3));
        check("div_a", 64'(div_a_o), 64'(m_a));
        check("div_b", 64'(div_b_o), 64'(m_b));
      end
      if (in_done) begin
        check("resp_data", 64'(resp_data_o), 64'(m_res));
        check("resp_rd", 64'(resp_rd_o), 64'(m_rd));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle (cycle 0) and run it to the end.
  // stall: cycles resp_ready_i stays low in DONE. flush_at: cycle (relative to
  // acceptance) in which flush_i is pulsed, 0 for none.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int stall, input int flush_at,
                       input logic [31:0] hand, input int hand_lat);
    int c0, lat, end_c;
    c0  = cyc;
    lat = div_lat(f3, a, b);
`ifdef DIV_RESULT_CACHE_EN
    if (mc_valid && mc_f3 == f3 && mc_a == a && mc_b == b) lat = 0;
`endif
    check("model_res", 64'(ref_div(f3, a, b)), 64'(hand));
    check("model_lat", 64'(lat), 64'(hand_lat));
    m_f3 = f3; m_a = a; m_b = b; m_rd = rd; m_res = ref_div(f3, a, b);
    run_lo = (lat > 0) ? c0 + 1 : INF;
    run_hi = c0 + lat;
    done_lo = c0 + lat + 1;
    done_hi = done_lo + stall;
    if (flush_at > 0 && flush_at <= lat) begin
      run_hi = c0 + flush_at; done_lo = INF; done_hi = INF;
    end else if (flush_at > 0) begin
      done_hi = c0 + flush_at;
    end
    end_c = (flush_at > 0) ? c0 + flush_at : done_hi;
    req_valid_i = 1'b1; req_funct3_i = f3; req_a_i = a; req_b_i = b; req_rd_i = rd;
    resp_ready_i = 1'b0; flush_i = 1'b0;
    step();
    while (cyc <= end_c) begin
      // Changing requests while busy must be ignored.
      req_funct3_i = 3'($urandom_range(4, 7));
      req_a_i = $urandom; req_b_i = $urandom; req_rd_i = 5'($urandom_range(0, 31));
      resp_ready_i = (flush_at == 0) && (cyc == done_hi);
      flush_i = (flush_at > 0) && (cyc == c0 + flush_at);
      step();
    end
    req_valid_i = 1'b0; resp_ready_i = 1'b0; flush_i = 1'b0;
    if (flush_at == 0 || flush_at > lat) begin
      mc_valid = 1'b1; mc_f3 = f3; mc_a = a; mc_b = b;
    end
  endtask

  // ALU traffic on the shared adder whenever the divider is not using it.
  initial begin
    forever begin
      step();
      if (alu_rand) begin
        alu_a_i = $urandom; alu_b_i = $urandom; alu_sub_i = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    step(); step();
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_resp_data", 64'(resp_data_o), 64'd0);
    check("rst_resp_rd", 64'(resp_rd_o), 64'd0);
    check("rst_div_en", 64'(div_en_o), 64'd0);
    check("rst_div_funct3", 64'(div_funct3_o), 64'd0);
    check("rst_div_a", 64'(div_a_o), 64'd0);
    check("rst_div_b", 64'(div_b_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Shared adder in IDLE: 5-3 and 5+3.
    alu_a_i = 32'd5; alu_b_i = 32'd3; alu_sub_i = 1'b1;
    @(negedge clk);
    check("adder_sub_lit", 64'(adder_result_ext_o[33:1]), 64'h1_0000_0002);
    step();
    alu_sub_i = 1'b0;
    @(negedge clk);
    check("adder_add_lit", 64'(adder_result_ext_o[33:1]), 64'h0_0000_0008);
    step();
    alu_rand = 1'b1;

    do_op(DIVU, 32'd100, 32'd7, 5'd1, 0, 0, 32'd14, 34);
    do_op(REM, 32'hffff_fff9, 32'd2, 5'd2, 0, 0, 32'hffff_ffff, 34);
    do_op(DIV, 32'hffff_fff9, 32'd2, 5'd3, 0, 0, 32'hffff_fffd, 34);
    do_op(DIV, 32'd7, 32'd0, 5'd4, 0, 0, 32'hffff_ffff, 1);
    do_op(REMU, 32'd7, 32'd0, 5'd5, 0, 0, 32'd7, 1);
    do_op(DIVU, 32'd5, 32'h8000_0001, 5'd6, 0, 0, 32'd0, 1);
    do_op(REMU, 32'd0, 32'd5, 5'd7, 0, 0, 32'd0, 1);
    do_op(DIV, 32'h8000_0000, 32'hffff_ffff, 5'd8, 0, 0, 32'h8000_0000, 34);
    // Backpressure, then the next request right after the handshake.
    do_op(DIVU, 32'd1000, 32'd10, 5'd9, 10, 0, 32'd100, 34);
    do_op(REM, 32'd17, 32'd5, 5'd10, 2, 0, 32'd2, 34);
    // Flush in RUN cycle 10, then a full-latency division.
    do_op(DIV, 32'd100, 32'd3, 5'd11, 0, 10, 32'd33, 34);
    do_op(DIV, 32'd20, 32'd3, 5'd12, 0, 0, 32'd6, 34);
    // Flush while the response is pending: it is discarded.
    do_op(DIV, 32'd9, 32'd0, 5'd13, 3, 3, 32'hffff_ffff, 1);
    step();
    // Flush together with a request in IDLE: not accepted.
    req_valid_i = 1'b1; req_funct3_i = DIVU; req_a_i = 32'd50; req_b_i = 32'd5;
    flush_i = 1'b1;
    step();
    req_valid_i = 1'b0; flush_i = 1'b0;
    step(); step();
    // Repeated request (served from the cache when it is built in).
    do_op(DIVU, 32'd100, 32'd7, 5'd14, 0, 0, 32'd14, 34);
    do_op(DIVU, 32'd100, 32'd7, 5'd15, 1, 0, 32'd14, HIT_LAT);
    do_op(DIVU, 32'd100, 32'd8, 5'd16, 0, 0, 32'd12, 34);
    step(); step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
